// File: rtl/clock_gate_ctrl.sv
// Enable generator for one gated clock domain: wake on demand, idle-out after a programmable run.
// clk_en rises one edge after demand is seen in OFF; wake_ack follows WAKE_CYCLES edges later.
module clock_gate_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_WIDTH  = 8,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  auto_gate,
  input  logic [IDLE_WIDTH-1:0] idle_threshold,
  input  logic                  busy,
  input  logic                  wake_req,
  output logic                  wake_ack,
  output logic                  clk_en,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] gated_cycles
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            wake_cnt;
  logic [7:0]            wake_cnt_nxt;
  logic [IDLE_WIDTH-1:0] idle_cnt;
  logic [IDLE_WIDTH-1:0] idle_cnt_nxt;
  logic                  demand;
  logic [IDLE_WIDTH:0]   idle_inc;
  logic [IDLE_WIDTH:0]   thr_eff;
  logic                  idle_expired;

  assign demand       = wake_req | busy | ~auto_gate;
  // One extra bit so idle_cnt+1 never wraps before the compare.
  assign idle_inc     = {1'b0, idle_cnt} + (IDLE_WIDTH+1)'(1);
  assign thr_eff      = (idle_threshold == '0) ? (IDLE_WIDTH+1)'(1) : {1'b0, idle_threshold};
  assign idle_expired = (idle_inc >= thr_eff);

  always_comb begin
    state_nxt    = state;
    wake_cnt_nxt = wake_cnt;
    idle_cnt_nxt = idle_cnt;
    case (state)
      ST_OFF: begin
        if (demand) begin
          state_nxt    = ST_WAKE;
          wake_cnt_nxt = WAKE_LOAD;
          idle_cnt_nxt = '0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt == 8'd0) begin
          state_nxt    = ST_ON;
          idle_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt - 8'd1;
        end
      end
      ST_ON: begin
        if (demand) begin
          idle_cnt_nxt = '0;
        end else if (idle_expired) begin
          state_nxt    = ST_OFF;
          idle_cnt_nxt = '0;
        end else if (!(&idle_cnt)) begin
          idle_cnt_nxt = idle_inc[IDLE_WIDTH-1:0];
        end
      end
      default: begin
        state_nxt    = ST_OFF;
        wake_cnt_nxt = '0;
        idle_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ST_OFF;
      wake_cnt <= '0;
      idle_cnt <= '0;
      clk_en   <= 1'b0;
      wake_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
      clk_en   <= (state_nxt != ST_OFF);
      wake_ack <= (state_nxt == ST_ON);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      gated_cycles <= '0;
    end else if (stat_clr) begin
      gated_cycles <= '0;
    end else if ((state == ST_OFF) && !(&gated_cycles)) begin
      gated_cycles <= gated_cycles + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Randomised and directed bench for clock_gate_ctrl against a timestamp-based reference model.
module tb_clock_gate_ctrl;

  localparam int WC = 2;
  localparam int IW = 8;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          auto_gate;
  logic [IW-1:0] idle_threshold;
  logic          busy;
  logic          wake_req;
  logic          wake_ack;
  logic          clk_en;
  logic          stat_clr;
  logic [SW-1:0] gated_cycles;

  int total = 0;
  int bad   = 0;

  // Reference model: awake flag, edge index of the wake decision, idle run length.
  bit m_on;
  int m_n, m_wake, m_streak, m_gated;
  bit exp_en, exp_ack;

  clock_gate_ctrl #(.WAKE_CYCLES(WC), .IDLE_WIDTH(IW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst_b(rst_b), .auto_gate(auto_gate), .idle_threshold(idle_threshold),
    .busy(busy), .wake_req(wake_req), .wake_ack(wake_ack), .clk_en(clk_en),
    .stat_clr(stat_clr), .gated_cycles(gated_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_n = 0; m_wake = 0; m_streak = 0; m_gated = 0;
    exp_en = 0; exp_ack = 0;
  endtask

  task automatic model_edge();
    bit demand, was_off;
    int thr;
    demand  = wake_req | busy | ~auto_gate;
    thr     = (idle_threshold == 0) ? 1 : int'(idle_threshold);
    was_off = !m_on;
    if (!m_on) begin
      if (demand) begin m_on = 1; m_wake = m_n; m_streak = 0; end
    end else if (m_n > m_wake + WC) begin
      if (demand) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak >= thr) begin m_on = 0; m_streak = 0; end
      end
    end
    if (stat_clr) m_gated = 0;
    else if (was_off && m_gated < SMAX) m_gated++;
    exp_en  = m_on;
    exp_ack = m_on && (m_n >= m_wake + WC);
    m_n++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clk_en", clk_en, exp_en);
    chk("wake_ack", wake_ack, exp_ack);
    chk("gated_cycles", gated_cycles, m_gated);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called just after a step: drops reset mid-cycle and checks outputs clear without an edge.
  task automatic async_reset(input string tag);
    #2 rst_b = 1'b0;
    #1;
    chk({tag, "_en"}, clk_en, 0);
    chk({tag, "_ack"}, wake_ack, 0);
    chk({tag, "_gated"}, gated_cycles, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic wake_up();
    wake_req = 1'b1;
    steps(WC + 1);
    wake_req = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1; auto_gate = 1'b1; idle_threshold = 8'd4;
    busy = 1'b0; wake_req = 1'b0; stat_clr = 1'b0;
    model_reset();
    #2 rst_b = 1'b0;
    #1;
    chk("rst_en", clk_en, 0);
    chk("rst_ack", wake_ack, 0);
    chk("rst_gated", gated_cycles, 0);
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step();
      if (i < 5) chk("gated_seq", gated_cycles, i + 1);
    end
    chk("gated_sat", gated_cycles, SMAX);
    chk("off_en", clk_en, 0);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    chk("stat_clr", gated_cycles, 0);

    wake_req = 1'b1;
    step(); chk("lat_en", clk_en, 1); chk("lat_ack0", wake_ack, 0);
    step(); chk("lat_ack1", wake_ack, 0);
    step(); chk("lat_ack2", wake_ack, 1);
    wake_req = 1'b0; idle_threshold = 8'd4;
    steps(3); chk("idle3_on", clk_en, 1);
    step();   chk("idle4_off", clk_en, 0); chk("idle4_ack", wake_ack, 0);

    wake_up();
    steps(3);
    busy = 1'b1; step(); busy = 1'b0;
    steps(3); chk("busy_restart", clk_en, 1);
    step();   chk("busy_gate", clk_en, 0);

    wake_up();
    idle_threshold = 8'd0;
    step(); chk("thr0_gate", clk_en, 0);

    idle_threshold = 8'd10;
    wake_up();
    steps(5); chk("thr10_on", clk_en, 1);
    idle_threshold = 8'd2;
    step(); chk("thr_lower", clk_en, 0);

    auto_gate = 1'b0;
    steps(1000);
    chk("ag0_on", clk_en, 1);
    chk("ag0_ack", wake_ack, 1);
    auto_gate = 1'b1; idle_threshold = 8'd8;
    steps(7); chk("ag1_on7", clk_en, 1);
    step();   chk("ag1_off8", clk_en, 0);

    wake_req = 1'b1; step();
    async_reset("rst_wake");
    wake_req = 1'b0;
    step(); chk("post_rst_gated", gated_cycles, 1);
    wake_req = 1'b1; steps(4);
    async_reset("rst_on");
    wake_req = 1'b0;
    steps(2);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) auto_gate = ($urandom_range(0, 9) != 0);
      busy = ($urandom_range(0, 9) == 0);
      if (wake_req && wake_ack) wake_req = ($urandom_range(0, 3) == 0);
      else if (!wake_req) wake_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) idle_threshold = IW'($urandom_range(0, 6));
      stat_clr = ($urandom_range(0, 63) == 0);
      step();
      if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
